// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Loadable down-counter with valid/ready load handshake,
//               prescaler, one-shot or periodic reload and a one-cycle
//               expiry pulse. Counts expiries since the last accepted load.
//               Optional trace output: define COUNTDOWN_TIMER_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_periodic,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] counter_out,
  output logic             busy,
  output logic             expired,
  output logic [7:0]       expire_count
);

  // Prescaler needs at least one bit even when every enabled cycle ticks.
  localparam int              c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [c_PW-1:0]  r_pre;
  logic [c_PW-1:0]  w_pre_next;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_next;
  logic             r_periodic;
  logic             w_periodic_next;
  logic [WIDTH-1:0] w_counter_next;
  logic             w_busy_next;
  logic             w_expired_next;
  logic [7:0]       w_ecount_next;
  logic [7:0]       w_ecount_inc;

  assign load_ready   = (r_state == IDLE);
  // Expiry count saturates rather than wrapping.
  assign w_ecount_inc = (expire_count == 8'hFF) ? expire_count : expire_count + 8'd1;

  // State and output registers; reset takes effect immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_pre        <= '0;
      r_reload     <= '0;
      r_periodic   <= 1'b0;
      counter_out  <= '0;
      busy         <= 1'b0;
      expired      <= 1'b0;
      expire_count <= 8'd0;
    end else begin
      r_state      <= w_state_next;
      r_pre        <= w_pre_next;
      r_reload     <= w_reload_next;
      r_periodic   <= w_periodic_next;
      counter_out  <= w_counter_next;
      busy         <= w_busy_next;
      expired      <= w_expired_next;
      expire_count <= w_ecount_next;
    end
  end

  // Next-state logic: load handshake in IDLE, prescaled countdown in RUN.
  always_comb begin
    w_state_next    = r_state;
    w_pre_next      = r_pre;
    w_reload_next   = r_reload;
    w_periodic_next = r_periodic;
    w_counter_next  = counter_out;
    w_busy_next     = busy;
    w_expired_next  = 1'b0;
    w_ecount_next   = expire_count;
    case (r_state)
      IDLE: begin
        // abort has no meaning here; a pending load always wins.
        if (load_valid) begin
          w_counter_next  = load_value;
          w_reload_next   = load_value;
          w_periodic_next = load_periodic;
          w_pre_next      = '0;
          if (load_value != '0) begin
            w_state_next  = RUN;
            w_busy_next   = 1'b1;
            w_ecount_next = 8'd0;
          end else begin
            // A zero count has already elapsed: report it immediately.
            w_expired_next = 1'b1;
            w_ecount_next  = 8'd1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          // Counter keeps its value so the consumer can see where it stopped.
          w_state_next = IDLE;
          w_busy_next  = 1'b0;
          w_pre_next   = '0;
        end else if (enable) begin
          if (r_pre == c_PRE_LAST) begin
            w_pre_next = '0;
            if (counter_out > c_ONE) begin
              w_counter_next = counter_out - c_ONE;
            end else begin
              w_expired_next = 1'b1;
              w_ecount_next  = w_ecount_inc;
              if (r_periodic) begin
                // Reload directly so zero is never shown in periodic mode.
                w_counter_next = r_reload;
              end else begin
                w_counter_next = '0;
                w_busy_next    = 1'b0;
                w_state_next   = IDLE;
              end
            end
          end else begin
            w_pre_next = r_pre + c_PW'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

`ifdef COUNTDOWN_TIMER_TRACE_EN
  // Simulation trace of expiry and abort events.
  always_ff @(posedge clock) begin
    if (reset && w_expired_next)
      $display("(%0t ns) Timer expired, count %0d", $time, w_ecount_next);
    if (reset && (r_state == RUN) && abort)
      $display("(%0t ns) Timer aborted at %0d", $time, counter_out);
  end
`endif

endmodule
`default_nettype wire
